// File: rtl/mul8b_pkg.sv
// Shared definitions for the sequential 8x8 shift-and-add multiplier.
// Holds the FSM state encoding and the fixed datapath widths.
package mul8b_pkg;

    localparam int MUL_W  = 8;
    localparam int PROD_W = 16;
    localparam int STEPS  = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/adder8b.sv
// 8-bit ripple adder from the arithmetic library.
// Ports: A, B (8-bit addends), S (8-bit sum), Cout (carry out).
module adder8b (
    output logic [7:0] S,
    output logic       Cout,
    input  logic [7:0] A,
    input  logic [7:0] B
);

    assign {Cout, S} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/mul8b_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier, one step per clock.
// Ports: clk, rst (async high), start/A/B in; ready, busy, done, P (16-bit) out.
module mul8b_seq
    import mul8b_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MUL_W-1:0]  A,
    input  logic [MUL_W-1:0]  B,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] P
);

    state_e             state_q;
    logic [MUL_W-1:0]   m_q;
    logic [MUL_W-1:0]   q_q;
    logic [MUL_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PROD_W-1:0]  p_q;

    logic [MUL_W-1:0]   addend_d;
    logic [MUL_W-1:0]   sum_d;
    logic               carry_d;
    logic [MUL_W-1:0]   acc_d;
    logic [MUL_W-1:0]   qn_d;

    // Partial product: add M only when the current multiplier bit is set.
    assign addend_d = q_q[0] ? m_q : '0;

    adder8b u_add (
        .S    (sum_d),
        .Cout (carry_d),
        .A    (acc_q),
        .B    (addend_d)
    );

    // Shift {C, S, Q} right by one; the carry lands in ACC[7].
    assign acc_d = {carry_d, sum_d[MUL_W-1:1]};
    assign qn_d  = {sum_d[0], q_q[MUL_W-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= A;
                        q_q     <= B;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    q_q   <= qn_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        p_q     <= {acc_d, qn_d};
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status decoded from the state register only, never from start.
    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign P     = p_q;

endmodule

// File: tb/tb_mul8b_seq.sv
// Self-checking bench for mul8b_seq using an expected-product queue.
// Products are pushed at accept time and popped when done is seen.
module tb_mul8b_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  A = 8'h00;
    logic [7:0]  B = 8'h00;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] P;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    mul8b_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    task automatic accept_op(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready got=%b exp=1", ready);
        end
        A = a;
        B = b;
        start = 1'b1;
        exp_q.push_back(16'(a) * 16'(b));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int n;
        bit seen;
        logic [15:0] e;
        seen = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout got=no_done exp=done", name);
        end else begin
            if (exp_lat >= 0) begin
                checks++;
                if (n != exp_lat) begin
                    failures++;
                    $display("FAIL %s_latency got=%0d exp=%0d", name, n, exp_lat);
                end
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s_queue got=empty exp=entry", name);
            end else begin
                e = exp_q.pop_front();
                if (P !== e) begin
                    failures++;
                    $display("FAIL %s_P got=%h exp=%h", name, P, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        #22 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ready, busy, done} !== 3'b100 || P !== 16'h0000) begin
            failures++;
            $display("FAIL reset got=rdy%b bsy%b dn%b P=%h exp=rdy1 bsy0 dn0 P=0000",
                     ready, busy, done, P);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int busy_n;
        logic [15:0] e;
        busy_n = 0;
        accept_op(8'h0D, 8'h0B);
        repeat (8) begin
            @(negedge clk);
            if (busy === 1'b1 && done === 1'b0 && ready === 1'b0) busy_n++;
        end
        checks++;
        if (busy_n != 8) begin
            failures++;
            $display("FAIL basic_busy got=%0d exp=8", busy_n);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got=dn%b bsy%b rdy%b exp=dn1 bsy0 rdy0",
                     done, busy, ready);
        end
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (P !== e) begin
            failures++;
            $display("FAIL basic_P got=%h exp=%h", P, e);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_pulse got=dn%b rdy%b exp=dn0 rdy1", done, ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] as[3];
        logic [7:0] bs[3];
        int acc_t[3];
        int nacc;
        int ndone;
        logic [15:0] held;
        logic [15:0] e;
        as = '{8'hFF, 8'h00, 8'h80};
        bs = '{8'hFF, 8'hFF, 8'h02};
        nacc = 0;
        ndone = 0;
        @(negedge clk);
        A = as[0];
        B = bs[0];
        start = 1'b1;
        held = P;
        for (int t = 0; t < 60 && ndone < 3; t++) begin
            if (done === 1'b1) begin
                checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                if (P !== e) begin
                    failures++;
                    $display("FAIL b2b_P%0d got=%h exp=%h", ndone, P, e);
                end
                held = e;
                ndone++;
            end else begin
                checks++;
                if (P !== held) begin
                    failures++;
                    $display("FAIL b2b_hold got=%h exp=%h", P, held);
                end
            end
            if (ready === 1'b1 && nacc < 3) begin
                exp_q.push_back(16'(A) * 16'(B));
                acc_t[nacc] = t;
                nacc++;
            end else if (nacc < 3) begin
                A = as[nacc];
                B = bs[nacc];
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (ndone != 3 || nacc != 3) begin
            failures++;
            $display("FAIL b2b_count got=acc%0d done%0d exp=acc3 done3", nacc, ndone);
        end else begin
            checks++;
            if (acc_t[1] - acc_t[0] != 10 || acc_t[2] - acc_t[1] != 10) begin
                failures++;
                $display("FAIL b2b_spacing got=%0d,%0d exp=10,10",
                         acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
            end
        end
    endtask

    task automatic test_start_busy();
        int nd;
        logic [15:0] e;
        nd = 0;
        accept_op(8'h03, 8'h05);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        repeat (3) @(negedge clk);
        A = 8'hFF;
        B = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                nd++;
                checks++;
                if (P !== e) begin
                    failures++;
                    $display("FAIL busy_start_P got=%h exp=%h", P, e);
                end
            end
        end
        checks++;
        if (nd != 1) begin
            failures++;
            $display("FAIL busy_start_pulses got=%0d exp=1", nd);
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        nd = 0;
        accept_op(8'hFF, 8'hFF);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        checks++;
        if ({ready, busy, done} !== 3'b100 || P !== 16'h0000) begin
            failures++;
            $display("FAIL rst_mid got=rdy%b bsy%b dn%b P=%h exp=rdy1 bsy0 dn0 P=0000",
                     ready, busy, done, P);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin
            failures++;
            $display("FAIL rst_mid_done got=%0d exp=0", nd);
        end
        accept_op(8'h02, 8'h03);
        wait_done("rst_after", 8);
    endtask

    task automatic test_operand_change();
        accept_op(8'h10, 8'h10);
        @(negedge clk);
        A = 8'h00;
        B = 8'h00;
        wait_done("opchg", 7);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_busy();
        test_reset_mid();
        test_operand_change();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
